// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and state type for the data memory responder
// no ports; imported by the responder, its interface and the bench
package mips_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmr_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake between core and memory
// master = core side, slave = memory side
interface data_mem_responder_if #(
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DATA_W = mips_pkg::DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_ram_core.sv
// data_ram_core: single-write RAM, registered commit and debug read ports
// ports: clock, we/re/addr/wdata/rdata (commit), dbg_addr/dbg_rdata (debug)
module data_ram_core #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata
);

  logic [DW-1:0] mem [DEPTH];

  // read-before-write: a debug read of the word being written sees the
  // old contents this cycle and the new contents on the next one
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
    dbg_rdata <= mem[dbg_addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: one-at-a-time load/store responder, fixed latency
// ports: clock, reset, bus (req/rsp handshake), dbg_addr/dbg_data, txn_count
module data_mem_responder #(
  parameter int ADDR_W  = mips_pkg::ADDR_W,
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                clock,
  input  logic                reset,
  data_mem_responder_if.slave bus,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data,
  output logic [15:0]         txn_count
);

  import mips_pkg::*;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "data_mem_responder: LATENCY must be 1..15");
  end

  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $fatal(1, "data_mem_responder: DEPTH must be 1..2**ADDR_W");
  end

  dmr_state_t        state_q;
  dmr_state_t        state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ld_q;
  logic              err_q;
  logic [15:0]       txn_q;
  logic              dbg_ok_q;

  logic              accept;
  logic              commit;
  logic              rsp_hs;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ok;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W-1:0] ram_dbg;

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign accept = bus.req_valid && bus.req_ready;
  assign rsp_hs = (state_q == RESP) && bus.rsp_ready;

  // with LATENCY 1 the commit lands on the accept edge, before the
  // request latches hold anything, so take the live request then
  assign c_we    = (state_q == IDLE) ? bus.req_we    : we_q;
  assign c_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign c_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign c_ok    = int'(c_addr) < DEPTH;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ld_q     <= 1'b0;
      err_q    <= 1'b0;
      txn_q    <= '0;
      dbg_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        ld_q  <= c_ok && !c_we;
        err_q <= !c_ok;
      end
      if (rsp_hs) begin
        txn_q <= txn_q + 16'd1;
      end
      dbg_ok_q <= (int'(dbg_addr) < DEPTH);
    end
  end

  data_ram_core #(
    .DEPTH (DEPTH),
    .AW    (IW),
    .DW    (DATA_W)
  ) u_ram (
    .clock     (clock),
    .we        (commit && c_ok && c_we),
    .re        (commit && c_ok && !c_we),
    .addr      (c_addr[IW-1:0]),
    .wdata     (c_wdata),
    .rdata     (ram_rd),
    .dbg_addr  (dbg_addr[IW-1:0]),
    .dbg_rdata (ram_dbg)
  );

  // the RAM read registers are not reset; these flags zero the outputs
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = ld_q ? ram_rd : '0;
  assign bus.rsp_err   = err_q;
  assign dbg_data      = dbg_ok_q ? ram_dbg : '0;
  assign txn_count     = txn_q;

endmodule
